imem_program_loader: RTL and testbench

//  Writer side of the instruction memory. Accepts a byte stream (UART/debug link) framed as
//  16-bit word count + payload, packs bytes little-endian into 32-bit words and drives the

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_program_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_program_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its program loader.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 64;
  localparam int unsigned IMEM_ADDR_W = 32;
  localparam int unsigned IMEM_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words.
// Byte k of a word lands in o_word[8k+7:8k]; o_word_valid pulses the cycle
// after the fourth byte and o_word is stable during that pulse.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_byte_valid,
  input  logic [IMEM_BYTE_W-1:0] i_byte,
  output logic [1:0]             o_lane,
  output logic                   o_word_valid,
  output logic [31:0]            o_word
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic        r_word_valid;

  // Byte-lane counter and word assembly; word_valid follows the last lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_byte_valid && (r_lane == 2'd3);
      if (i_clear) begin
        r_lane <= '0;
      end else if (i_byte_valid) begin
        r_word[{r_lane, 3'b000} +: IMEM_BYTE_W] <= i_byte;
        r_lane                                  <= r_lane + 2'd1;
      end
    end
  end

  assign o_lane       = r_lane;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_program_loader.sv
// Instruction memory program loader: receives a framed byte stream
// (16-bit little-endian word count + payload), writes words into imem and
// holds the core in reset until a frame completes successfully.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  loader_state_t r_state;
  logic          r_s_ready;
  logic          r_hdr_hi;
  logic [7:0]    r_len_lo;
  logic [15:0]   r_len;
  logic [15:0]   r_word_count;
  logic [31:0]   r_wr_addr;
  logic          r_done;
  logic          r_error;
  logic          r_cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif

  logic          w_accept;
  logic          w_idle_like;
  logic          w_pack_clear;
  logic          w_pack_byte;
  logic [1:0]    w_lane;
  logic          w_word_valid;
  logic [31:0]   w_word;
  logic [15:0]   w_len_rx;

  assign w_accept     = s_valid && r_s_ready;
  assign w_idle_like  = (r_state == IDLE) || (r_state == DONE) || (r_state == ERROR);
  assign w_pack_clear = start && w_idle_like;
  assign w_pack_byte  = w_accept && (r_state == LOAD);
  assign w_len_rx     = {s_data, r_len_lo};

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_pack_clear),
    .i_byte_valid (w_pack_byte),
    .i_byte       (s_data),
    .o_lane       (w_lane),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Frame sequencing, addressing, counting and registered status outputs.
  // s_ready is computed alongside the next state so it drops exactly for
  // the write cycle following each fourth payload byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_s_ready    <= 1'b0;
      r_hdr_hi     <= 1'b0;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_word_count <= '0;
      r_wr_addr    <= BASE_ADDR;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= HDR;
            r_s_ready    <= 1'b1;
            r_hdr_hi     <= 1'b0;
            r_len        <= '0;
            r_word_count <= '0;
            r_wr_addr    <= BASE_ADDR;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
          end
        end
        HDR: begin
          if (w_accept) begin
            if (!r_hdr_hi) begin
              r_len_lo <= s_data;
              r_hdr_hi <= 1'b1;
            end else begin
              r_len <= w_len_rx;
              if (w_len_rx == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state    <= CHK;
`else
                r_state    <= DONE;
                r_s_ready  <= 1'b0;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
`endif
              end else if (w_len_rx > DEPTH_W) begin
                r_state   <= ERROR;
                r_s_ready <= 1'b0;
                r_error   <= 1'b1;
              end else begin
                r_state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + s_data;
`endif
            if (w_lane == 2'd3) r_s_ready <= 1'b0;
          end
          if (w_word_valid) begin
            if (r_word_count < DEPTH_W) r_word_count <= r_word_count + 16'd1;
            if (r_wr_addr < LAST_ADDR)  r_wr_addr    <= r_wr_addr + 32'd4;
            if (r_word_count + 16'd1 >= r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= CHK;
              r_s_ready  <= 1'b1;
`else
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
`endif
            end else begin
              r_s_ready <= 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            r_s_ready <= 1'b0;
            if (s_data == r_sum) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign wr_en      = w_word_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = w_word;
  assign word_count = r_word_count;
  assign busy       = (r_state == HDR) || (r_state == LOAD) || (r_state == CHK);
  assign done       = r_done;
  assign error      = r_error;
  assign cpu_hold   = r_cpu_hold;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed testbench for imem_program_loader (default DEPTH=64, BASE_ADDR=0).
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  logic [31:0] t4_words[8] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000000,
                               32'hFFFFFFFF, 32'h13579BDF, 32'h2468ACE0, 32'hCAFEF00D};

  imem_program_loader #(.DEPTH(64), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  // Record every imem write seen mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // All tasks below start and end on a falling edge.
  task automatic idle(input int unsigned n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Present a byte and wait until the DUT takes it; s_valid is left high.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check_eq("s_ready_wait", {31'b0, s_ready}, 32'd1);
      s_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic wait_end();
    int unsigned n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("frame_end_wait", {31'b0, done | error}, 32'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sum;
    logic [31:0] w;

    // ---- 1. reset ----
    rst = 1'b1; start = 1'b0; s_valid = 1'b1; s_data = 8'h55;
    @(negedge clk); @(negedge clk);
    check_eq("rst_cpu_hold_in_reset", {31'b0, cpu_hold}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_s_ready_low", {31'b0, s_ready}, 32'd0);
    end
    check_eq("rst_wr_en",      {31'b0, wr_en}, 32'd0);
    check_eq("rst_busy",       {31'b0, busy}, 32'd0);
    check_eq("rst_done",       {31'b0, done}, 32'd0);
    check_eq("rst_error",      {31'b0, error}, 32'd0);
    check_eq("rst_cpu_hold",   {31'b0, cpu_hold}, 32'd1);
    check_eq("rst_wr_addr",    wr_addr, 32'h0);
    check_eq("rst_wr_data",    wr_data, 32'h0);
    check_eq("rst_word_count", {16'b0, word_count}, 32'd0);
    check_eq("rst_no_writes",  32'(log_addr.size()), 32'd0);
    idle(1);

    // ---- 2. two-word program ----
    clear_log();
    pulse_start();
    check_eq("t2_busy",    {31'b0, busy}, 32'd1);
    check_eq("t2_s_ready", {31'b0, s_ready}, 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'hA0); send_byte(8'h00);
    check_eq("t2_wr_en_latency",  {31'b0, wr_en}, 32'd1);
    check_eq("t2_bubble_s_ready", {31'b0, s_ready}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h96);
    idle(1);
    wait_end();
`else
    @(negedge clk);
    check_eq("t2_done_latency", {31'b0, done}, 32'd1);
    idle(1);
`endif
    check_eq("t2_writes",     32'(log_addr.size()), 32'd2);
    check_eq("t2_addr0",      log_addr[0], 32'h0);
    check_eq("t2_data0",      log_data[0], 32'h00500013);
    check_eq("t2_addr1",      log_addr[1], 32'h4);
    check_eq("t2_data1",      log_data[1], 32'h00A00093);
    check_eq("t2_word_count", {16'b0, word_count}, 32'd2);
    check_eq("t2_done",       {31'b0, done}, 32'd1);
    check_eq("t2_error",      {31'b0, error}, 32'd0);
    check_eq("t2_cpu_hold",   {31'b0, cpu_hold}, 32'd0);
    check_eq("t2_busy_end",   {31'b0, busy}, 32'd0);

    // ---- 3. oversize header (65 > DEPTH) ----
    clear_log();
    pulse_start();
    check_eq("t3_done_cleared", {31'b0, done}, 32'd0);
    send_byte(8'h41); send_byte(8'h00);
    check_eq("t3_error_now", {31'b0, error}, 32'd1);
    idle(3);
    check_eq("t3_error",      {31'b0, error}, 32'd1);
    check_eq("t3_done",       {31'b0, done}, 32'd0);
    check_eq("t3_cpu_hold",   {31'b0, cpu_hold}, 32'd1);
    check_eq("t3_no_writes",  32'(log_addr.size()), 32'd0);
    check_eq("t3_s_ready",    {31'b0, s_ready}, 32'd0);
    check_eq("t3_word_count", {16'b0, word_count}, 32'd0);

    // ---- zero-length frame ----
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(1);
    wait_end();
    check_eq("len0_done",       {31'b0, done}, 32'd1);
    check_eq("len0_error",      {31'b0, error}, 32'd0);
    check_eq("len0_no_writes",  32'(log_addr.size()), 32'd0);
    check_eq("len0_word_count", {16'b0, word_count}, 32'd0);
    check_eq("len0_cpu_hold",   {31'b0, cpu_hold}, 32'd0);

    // ---- 4. 8-word frame with random gaps, start while busy ----
    clear_log();
    sum = 8'h00;
    pulse_start();
    send_byte(8'h08); send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      w = t4_words[i];
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, 1));
        send_byte(w[8*k +: 8]);
        sum = sum + w[8*k +: 8];
      end
      if (i == 2) pulse_start();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    idle($urandom_range(0, 1));
    send_byte(sum);
`endif
    idle(1);
    wait_end();
    check_eq("t4_writes", 32'(log_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t4_addr%0d", i), log_addr[i], 32'(4 * i));
      check_eq($sformatf("t4_data%0d", i), log_data[i], t4_words[i]);
    end
    check_eq("t4_word_count", {16'b0, word_count}, 32'd8);
    check_eq("t4_done",       {31'b0, done}, 32'd1);
    check_eq("t4_cpu_hold",   {31'b0, cpu_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- 5. wrong checksum, then retry ----
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h00);
    idle(1);
    wait_end();
    check_eq("t5_error",    {31'b0, error}, 32'd1);
    check_eq("t5_done",     {31'b0, done}, 32'd0);
    check_eq("t5_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check_eq("t5_writes",   32'(log_addr.size()), 32'd1);
    check_eq("t5_data0",    log_data[0], 32'h44332211);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA);
    idle(1);
    wait_end();
    check_eq("t5_retry_done",     {31'b0, done}, 32'd1);
    check_eq("t5_retry_error",    {31'b0, error}, 32'd0);
    check_eq("t5_retry_cpu_hold", {31'b0, cpu_hold}, 32'd0);
`endif

    // ---- 6. reset mid-frame after 2 of 4 words ----
    clear_log();
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
    idle(3);
    check_eq("t6_pre_word_count", {16'b0, word_count}, 32'd2);
    check_eq("t6_pre_busy",       {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_wr_en",      {31'b0, wr_en}, 32'd0);
    check_eq("t6_word_count", {16'b0, word_count}, 32'd0);
    check_eq("t6_cpu_hold",   {31'b0, cpu_hold}, 32'd1);
    check_eq("t6_busy",       {31'b0, busy}, 32'd0);
    check_eq("t6_s_ready",    {31'b0, s_ready}, 32'd0);
    check_eq("t6_done",       {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check_eq("t6_idle_busy",   {31'b0, busy}, 32'd0);
    check_eq("t6_writes_kept", 32'(log_addr.size()), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
